// File: rtl/mem_store_buffer.sv
// mem_store_buffer: post-commit store buffer between memory1 and the dcache write port.
// Stores enqueue lane-aligned, drain in order over a valid/ready handshake, and
// loads look the buffer up for store-to-load forwarding.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_enq_*, o_enq_rdy          store enqueue (pa, byte_type, unaligned data, cached MAT)
//   i_ld_*                      load lookup (valid, pa, byte_type, cached MAT)
//   o_ld_fwd_hit/data, o_ld_stall  forwarding result and memory1 hold request
//   o_dc_wr_*, i_dc_wr_rdy      head entry presented to the dcache
//   o_empty, o_count            occupancy for fences/ertn
module mem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int FWD_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_enq_valid,
    output logic                     o_enq_rdy,
    input  logic [ADDR_W-1:0]        i_enq_pa,
    input  logic [1:0]               i_enq_byte_type,
    input  logic [31:0]              i_enq_data,
    input  logic                     i_enq_cached,
    input  logic                     i_ld_valid,
    input  logic [ADDR_W-1:0]        i_ld_pa,
    input  logic [1:0]               i_ld_byte_type,
    input  logic                     i_ld_cached,
    output logic                     o_ld_fwd_hit,
    output logic [31:0]              o_ld_fwd_data,
    output logic                     o_ld_stall,
    output logic                     o_dc_wr_valid,
    input  logic                     i_dc_wr_rdy,
    output logic [ADDR_W-1:0]        o_dc_wr_pa,
    output logic [31:0]              o_dc_wr_data,
    output logic [3:0]               o_dc_wr_strb,
    output logic                     o_dc_wr_cached,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Zero strobe marks an illegal access (misaligned half/word or reserved type).
    function automatic logic [3:0] f_strb(input logic [1:0] bt, input logic [1:0] a);
        return (bt == 2'd0) ? (4'b0001 << a) :
               (bt == 2'd1 && !a[0]) ? (4'b0011 << a) :
               (bt == 2'd2 && a == 2'd0) ? 4'hF : 4'h0;
    endfunction

    function automatic logic [31:0] f_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    logic [DEPTH-1:0]  r_vld;
    logic [ADDR_W-3:0] r_pa     [DEPTH];
    logic [31:0]       r_data   [DEPTH];
    logic [3:0]        r_strb   [DEPTH];
    logic              r_cached [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic [3:0]        w_enq_strb;
    logic [31:0]       w_enq_data;
    logic              w_push;
    logic              w_pop;
    logic [3:0]        w_ld_req;
    logic [3:0]        w_cov;
    logic [31:0]       w_fwd;
    logic [PTR_W-1:0]  w_idx;
    logic              w_partial;

    assign w_enq_strb     = f_strb(i_enq_byte_type, i_enq_pa[1:0]);
    assign w_enq_data     = (i_enq_data << {i_enq_pa[1:0], 3'b000}) & f_mask(w_enq_strb);
    assign o_enq_rdy      = r_count < CNT_W'(DEPTH);
    assign o_empty        = r_count == '0;
    assign o_count        = r_count;
    assign w_push         = i_enq_valid && o_enq_rdy && (w_enq_strb != 4'h0);
    assign w_pop          = o_dc_wr_valid && i_dc_wr_rdy;
    assign o_dc_wr_valid  = !o_empty;
    assign o_dc_wr_pa     = {r_pa[r_head], 2'b00};
    assign o_dc_wr_data   = r_data[r_head];
    assign o_dc_wr_strb   = r_strb[r_head];
    assign o_dc_wr_cached = r_cached[r_head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (w_push) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pa[r_tail]     <= i_enq_pa[ADDR_W-1:2];
            r_data[r_tail]   <= w_enq_data;
            r_strb[r_tail]   <= w_enq_strb;
            r_cached[r_tail] <= i_enq_cached;
        end
    end

    // Walk entries oldest to youngest so a younger store overwrites older lanes.
    always_comb begin
        w_ld_req = f_strb(i_ld_byte_type, i_ld_pa[1:0]);
        w_cov    = 4'h0;
        w_fwd    = 32'h0;
        w_idx    = r_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if (r_vld[w_idx] && r_pa[w_idx] == i_ld_pa[ADDR_W-1:2]) begin
                w_cov = w_cov | (r_strb[w_idx] & w_ld_req);
                for (int b = 0; b < 4; b++)
                    if (r_strb[w_idx][b] && w_ld_req[b]) w_fwd[8*b +: 8] = r_data[w_idx][8*b +: 8];
            end
        end
    end

    // Without forwarding, any overlap must wait for the store to reach the dcache.
    assign w_partial     = (FWD_EN != 0) ? (w_cov != 4'h0 && w_cov != w_ld_req) : (w_cov != 4'h0);
    assign o_ld_fwd_hit  = (FWD_EN != 0) && i_ld_valid && i_ld_cached && (w_cov == w_ld_req) && (w_ld_req != 4'h0);
    assign o_ld_stall    = i_ld_valid && ((!i_ld_cached && !o_empty) || (i_ld_cached && w_partial));
    assign o_ld_fwd_data = ((FWD_EN != 0) && i_ld_valid) ? w_fwd : 32'h0;
endmodule

// File: tb/tb_mem_store_buffer.sv
// tb_mem_store_buffer: directed and random checks of mem_store_buffer against a queue model.
module tb_mem_store_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enq_valid, enq_cached, ld_valid, ld_cached, dc_wr_rdy;
    logic [31:0] enq_pa, enq_data, ld_pa;
    logic [1:0]  enq_bt, ld_bt;

    logic        o_enq_rdy, o_hit, o_stall, o_dc_valid, o_dc_cached, o_empty;
    logic [31:0] o_fwd_data, o_dc_pa, o_dc_data;
    logic [3:0]  o_dc_strb;
    logic [2:0]  o_count;

    logic        f_enq_rdy, f_hit, f_stall, f_dc_valid, f_dc_cached, f_empty;
    logic [31:0] f_fwd_data, f_dc_pa, f_dc_data;
    logic [3:0]  f_dc_strb;
    logic [2:0]  f_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
        logic [3:0]  s;
        logic        c;
    } ent_t;
    ent_t        q[$];
    logic [31:0] drained[$];

    always #5 clk = ~clk;

    mem_store_buffer #(.DEPTH(4), .ADDR_W(32), .FWD_EN(1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .i_enq_valid(enq_valid), .o_enq_rdy(o_enq_rdy), .i_enq_pa(enq_pa),
        .i_enq_byte_type(enq_bt), .i_enq_data(enq_data), .i_enq_cached(enq_cached),
        .i_ld_valid(ld_valid), .i_ld_pa(ld_pa), .i_ld_byte_type(ld_bt), .i_ld_cached(ld_cached),
        .o_ld_fwd_hit(o_hit), .o_ld_fwd_data(o_fwd_data), .o_ld_stall(o_stall),
        .o_dc_wr_valid(o_dc_valid), .i_dc_wr_rdy(dc_wr_rdy), .o_dc_wr_pa(o_dc_pa),
        .o_dc_wr_data(o_dc_data), .o_dc_wr_strb(o_dc_strb), .o_dc_wr_cached(o_dc_cached),
        .o_empty(o_empty), .o_count(o_count)
    );

    mem_store_buffer #(.DEPTH(4), .ADDR_W(32), .FWD_EN(0)) u1 (
        .clk(clk), .rst_n(rst_n),
        .i_enq_valid(enq_valid), .o_enq_rdy(f_enq_rdy), .i_enq_pa(enq_pa),
        .i_enq_byte_type(enq_bt), .i_enq_data(enq_data), .i_enq_cached(enq_cached),
        .i_ld_valid(ld_valid), .i_ld_pa(ld_pa), .i_ld_byte_type(ld_bt), .i_ld_cached(ld_cached),
        .o_ld_fwd_hit(f_hit), .o_ld_fwd_data(f_fwd_data), .o_ld_stall(f_stall),
        .o_dc_wr_valid(f_dc_valid), .i_dc_wr_rdy(dc_wr_rdy), .o_dc_wr_pa(f_dc_pa),
        .o_dc_wr_data(f_dc_data), .o_dc_wr_strb(f_dc_strb), .o_dc_wr_cached(f_dc_cached),
        .o_empty(f_empty), .o_count(f_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [1:0] bt);
        return (bt == 2'd0) ? 1 : (bt == 2'd1) ? 2 : 4;
    endfunction

    // Requested byte lanes from size and offset; zero for illegal accesses.
    function automatic logic [3:0] req_strb(input logic [1:0] bt, input logic [1:0] a);
        int sz = size_of(bt);
        if (bt == 2'd3 || (int'(a) % sz) != 0) return 4'h0;
        return 4'(((1 << sz) - 1) << a);
    endfunction

    task automatic check_model();
        int          n = q.size();
        logic [3:0]  r = req_strb(ld_bt, ld_pa[1:0]);
        logic [3:0]  c = 4'h0;
        logic [31:0] fd = 32'h0;
        logic        hit, base, st1, st0;
        foreach (q[i])
            if (q[i].w == ld_pa[31:2]) begin
                c |= q[i].s & r;
                for (int b = 0; b < 4; b++)
                    if (q[i].s[b] && r[b]) fd[8*b +: 8] = q[i].d[8*b +: 8];
            end
        hit  = ld_valid && ld_cached && r != 0 && c == r;
        base = ld_valid && !ld_cached && n != 0;
        st1  = base || (ld_valid && ld_cached && c != 0 && c != r);
        st0  = base || (ld_valid && c != 0);
        chk("m_empty", o_empty, n == 0);
        chk("m_count", o_count, n);
        chk("m_enq_rdy", o_enq_rdy, n < 4);
        chk("m_dc_valid", o_dc_valid, n != 0);
        if (n != 0) begin
            chk("m_dc_pa", o_dc_pa, {q[0].w, 2'b00});
            chk("m_dc_data", o_dc_data, q[0].d);
            chk("m_dc_strb", o_dc_strb, q[0].s);
            chk("m_dc_cached", o_dc_cached, q[0].c);
        end
        chk("m_hit", o_hit, hit);
        chk("m_stall", o_stall, st1);
        if (!ld_valid) chk("m_fwd_zero", o_fwd_data, 0);
        else if (hit) chk("m_fwd_data", o_fwd_data, fd);
        chk("m0_hit", f_hit, 0);
        chk("m0_stall", f_stall, st0);
    endtask

    task automatic model_update();
        int          n = q.size();
        int          sz = size_of(enq_bt);
        logic [63:0] m = (64'd1 << (8 * sz)) - 1;
        ent_t        e;
        logic        push = enq_valid && req_strb(enq_bt, enq_pa[1:0]) != 0 && n < 4;
        e.w = enq_pa[31:2];
        e.s = req_strb(enq_bt, enq_pa[1:0]);
        e.d = 32'((64'(enq_data) & m) << (8 * enq_pa[1:0]));
        e.c = enq_cached;
        if (n > 0 && dc_wr_rdy) void'(q.pop_front());
        if (push) q.push_back(e);
    endtask

    task automatic cycle();
        #1;
        check_model();
        if (o_dc_valid && dc_wr_rdy) drained.push_back(o_dc_data);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] pa, input logic [1:0] bt, input logic [31:0] d, input logic c);
        enq_valid = v; enq_pa = pa; enq_bt = bt; enq_data = d; enq_cached = c;
    endtask

    task automatic look(input logic v, input logic [31:0] pa, input logic [1:0] bt, input logic c);
        ld_valid = v; ld_pa = pa; ld_bt = bt; ld_cached = c;
    endtask

    task automatic drain();
        put(0, 0, 0, 0, 1);
        look(0, 0, 0, 1);
        dc_wr_rdy = 1;
        repeat (6) cycle();
        #1;
        chk("drain_empty", o_empty, 1);
    endtask

    initial begin
        rst_n = 0;
        put(0, 0, 0, 0, 1);
        look(0, 0, 0, 1);
        dc_wr_rdy = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dc_valid", o_dc_valid, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_count", o_count, 0);
        chk("rst_enq_rdy", o_enq_rdy, 1);
        chk("rst_hit", o_hit, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_fwd", o_fwd_data, 0);
        rst_n = 1;

        // Word store drains straight through.
        dc_wr_rdy = 1;
        put(1, 32'h1000, 2, 32'hDEADBEEF, 1);
        cycle();
        put(0, 0, 0, 0, 1);
        #1;
        chk("t1_valid", o_dc_valid, 1);
        chk("t1_pa", o_dc_pa, 32'h1000);
        chk("t1_strb", o_dc_strb, 4'hF);
        chk("t1_data", o_dc_data, 32'hDEADBEEF);
        cycle();
        #1;
        chk("t1_empty", o_empty, 1);

        // Byte forwarding; the no-forward instance must stall instead.
        dc_wr_rdy = 0;
        put(1, 32'h2003, 0, 32'h000000AB, 1);
        cycle();
        put(0, 0, 0, 0, 1);
        look(1, 32'h2003, 0, 1);
        #1;
        chk("t2_hit", o_hit, 1);
        chk("t2_data", o_fwd_data, 32'hAB000000);
        chk("t2_stall", o_stall, 0);
        chk("t2_nofwd_stall", f_stall, 1);
        chk("t2_nofwd_hit", f_hit, 0);
        cycle();
        drain();

        // Youngest store wins per lane.
        dc_wr_rdy = 0;
        put(1, 32'h3000, 2, 32'h11223344, 1);
        cycle();
        put(1, 32'h3002, 1, 32'h00005566, 1);
        cycle();
        put(0, 0, 0, 0, 1);
        look(1, 32'h3000, 2, 1);
        #1;
        chk("t3_hit", o_hit, 1);
        chk("t3_data", o_fwd_data, 32'h55663344);
        cycle();
        drain();

        // Partial overlap stalls until the store pops.
        dc_wr_rdy = 0;
        put(1, 32'h4001, 0, 32'h7F, 1);
        cycle();
        put(0, 0, 0, 0, 1);
        look(1, 32'h4000, 2, 1);
        #1;
        chk("t4_stall", o_stall, 1);
        chk("t4_hit", o_hit, 0);
        dc_wr_rdy = 1;
        cycle();
        #1;
        chk("t4_stall_clear", o_stall, 0);
        drain();

        // Full buffer, then release with a simultaneous drain.
        dc_wr_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            put(1, 32'h6000 + 32'(4 * i), 2, 32'(i), 1);
            cycle();
        end
        put(1, 32'h6010, 2, 32'h99, 0);
        #1;
        chk("t5_full_rdy", o_enq_rdy, 0);
        chk("t5_full_count", o_count, 4);
        cycle();
        dc_wr_rdy = 1;
        cycle();
        put(0, 0, 0, 0, 1);
        #1;
        chk("t5_count3", o_count, 3);
        chk("t5_rdy", o_enq_rdy, 1);
        drain();

        // Ten back-to-back stores across pointer wrap keep FIFO order.
        drained.delete();
        dc_wr_rdy = 1;
        for (int i = 0; i < 10; i++) begin
            put(1, 32'h9000 + 32'(4 * i), 2, 32'h100 + 32'(i), 1);
            cycle();
        end
        put(0, 0, 0, 0, 1);
        repeat (3) cycle();
        chk("t5_drain_n", drained.size(), 10);
        for (int i = 0; i < 10 && i < drained.size(); i++)
            chk("t5_order", drained[i], 32'h100 + 32'(i));

        // Uncached load waits for an empty buffer.
        dc_wr_rdy = 0;
        put(1, 32'h7000, 2, 32'h12345678, 0);
        cycle();
        put(0, 0, 0, 0, 1);
        look(1, 32'h8000, 2, 0);
        #1;
        chk("t6_stall", o_stall, 1);
        chk("t6_hit", o_hit, 0);
        cycle();
        dc_wr_rdy = 1;
        cycle();
        #1;
        chk("t6_empty", o_empty, 1);
        chk("t6_stall_clear", o_stall, 0);
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            int          sz;
            logic [1:0]  bt;
            logic [31:0] pa;
            bt = 2'($urandom_range(0, 2));
            sz = size_of(bt);
            pa = 32'h5000 + 32'($urandom_range(0, 3) * 4) + 32'(($urandom_range(0, 3) / sz) * sz);
            put(1'($urandom_range(0, 1)), pa, bt, $urandom, 1'($urandom_range(0, 3) != 0));
            bt = 2'($urandom_range(0, 2));
            sz = size_of(bt);
            pa = 32'h5000 + 32'($urandom_range(0, 3) * 4) + 32'(($urandom_range(0, 3) / sz) * sz);
            look(1'($urandom_range(0, 3) != 0), pa, bt, 1'($urandom_range(0, 4) != 0));
            dc_wr_rdy = 1'($urandom_range(0, 2) == 0);
            cycle();
        end
        drain();

        // Reset in the middle of a pending drain discards everything.
        dc_wr_rdy = 0;
        put(1, 32'hA000, 2, 32'hCAFEF00D, 1);
        cycle();
        cycle();
        put(0, 0, 0, 0, 1);
        dc_wr_rdy = 1;
        #1;
        rst_n = 0;
        #1;
        q.delete();
        chk("r_empty", o_empty, 1);
        chk("r_count", o_count, 0);
        chk("r_dc_valid", o_dc_valid, 0);
        rst_n = 1;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
- Parametrised post-commit store buffer between the memory1 stage and the dcache write port.
- Stores that have passed address translation with no exception enqueue here, lane-aligned, instead of writing the dcache directly; the pipeline no longer stalls on `dcache_busy` for stores.
- The buffer drains in order to the dcache over a valid/ready handshake.
- Loads in memory1 look up the buffer for store-to-load forwarding.
- A load stalls on partial overlap, and an uncached load stalls while the buffer is non-empty.

Parameters:
- DEPTH, 4: number of entries; power of two, ≥ 2.
- ADDR_W, 32: physical address width.
- FWD_EN, 1: 1 = byte-granular forwarding; 0 = any byte overlap with a buffered store stalls the load.

Ports:
- clk in 1: clock.
- rst_n in 1: asynchronous active-low reset.
- enq_valid in 1: store request; already filtered for flush/exception upstream.
- enq_rdy out 1: buffer can accept a store this cycle.
- enq_pa in ADDR_W: store physical address.
- enq_byte_type in 2: 0 byte, 1 half, 2 word; 3 reserved.
- enq_data in 32: unaligned store data; the low 8/16/32 bits are significant.
- enq_cached in 1: store MAT is cached.
- ld_valid in 1: load lookup active.
- ld_pa in ADDR_W: load physical address.
- ld_byte_type in 2: same encoding as enq_byte_type.
- ld_cached in 1: load MAT is cached.
- ld_fwd_hit out 1: every requested byte is supplied by the buffer.
- ld_fwd_data out 32: forwarded bytes in word-lane positions; unsupplied lanes are 0.
- ld_stall out 1: the load must hold in memory1.
- dc_wr_valid out 1: head entry is presented to the dcache.
- dc_wr_rdy in 1: dcache accepts the write.
- dc_wr_pa out ADDR_W: head entry address.
- dc_wr_data out 32: head entry lane-aligned data.
- dc_wr_strb out 4: head entry byte strobes.
- dc_wr_cached out 1: head entry MAT.
- empty out 1: no entries; used by fences (dbar/ibar) and ertn.
- count out $clog2(DEPTH)+1: occupancy.

Behaviour:
- **Reset:** rst_n low (async) clears head/tail pointers, count and all entry valid bits.
  - Resulting outputs: dc_wr_valid=0, empty=1, count=0, enq_rdy=1, ld_fwd_hit=0, ld_stall=0, ld_fwd_data=0.
  - Entry payloads are not reset.
  - Reset mid-drain discards all entries; a dcache write that was not yet accepted is lost by design.
- **Storage:** circular FIFO of DEPTH entries, each {valid, pa[ADDR_W-1:2], data[31:0], strb[3:0], cached}. Pointers are $clog2(DEPTH) bits and wrap at DEPTH-1→0.
- **Enqueue alignment (enq_pa[1:0] = a):**
  - byte: strb = 1<<a; data[8a+:8] = enq_data[7:0].
  - half: strb = 2'b11<<a; data[8a+:16] = enq_data[15:0].
  - word: strb = 4'hF; data = enq_data.
  - All other lanes are 0.
  - A misaligned half/word, or byte_type=3, is an illegal input: bench assertion; no enqueue occurs.
- **Enqueue handshake:** enq_rdy = (count < DEPTH), independent of a same-cycle drain (no full-bypass).
  - Enqueue occurs when enq_valid & enq_rdy.
  - The new entry is visible to drain and lookup on the next cycle (1-cycle latency).
- **Drain:**
  - dc_wr_valid = ~empty; the dc_wr_* fields reflect the head entry.
  - pa, data, strb and cached are held stable while dc_wr_valid & ~dc_wr_rdy.
  - Pop occurs on dc_wr_valid & dc_wr_rdy.
  - Simultaneous enqueue and pop: count is unchanged, both pointers advance.
  - Throughput is 1 entry/cycle when dc_wr_rdy is held high.
- **Load lookup:** combinational, over all valid entries including the head being popped this cycle.
  - Requested strobe R is derived from ld_pa/ld_byte_type with the same rules as enqueue.
  - Word match: entry.pa == ld_pa[ADDR_W-1:2].
  - For FWD_EN=1, each lane in R takes its byte from the youngest matching entry whose strb covers that lane.
  - Lane coverage C = OR of matching entries' strb ANDed with R.
  - ld_fwd_hit = ld_valid & ld_cached & (C == R) & (R ≠ 0).
  - ld_stall = ld_valid & ((~ld_cached & ~empty) | (ld_cached & C ≠ 0 & C ≠ R)).
  - C == 0 means no hit and no stall; the load reads the dcache.
  - FWD_EN=0: ld_fwd_hit=0; ld_stall additionally asserts when C ≠ 0.
  - ld_valid=0 forces ld_fwd_hit=0, ld_stall=0, ld_fwd_data=0.
- **Stall resolution:** ld_stall deasserts naturally once the overlapping entries drain.
- **Flush:** the buffer ignores pipeline flush; every enqueued entry is committed.

Test Plan:
- **Reset, then drain a word:** enqueue word pa=0x1000 data=0xDEADBEEF with dc_wr_rdy=1 → next cycle dc_wr_valid=1, dc_wr_pa=0x1000, strb=4'hF; one cycle later empty=1.
- **Byte alignment and forwarding:** enqueue byte pa=0x2003 data=0xAB, then load byte pa=0x2003 → ld_fwd_hit=1, ld_fwd_data=0xAB000000, ld_stall=0.
- **Youngest-wins merge:** enqueue word 0x3000=0x11223344, then half 0x3002=0x5566, hold dc_wr_rdy=0; load word 0x3000 → hit=1, data=0x55663344.
- **Partial overlap:** buffer holds byte 0x4001=0x7F; load word 0x4000 → ld_stall=1, hit=0. Raise dc_wr_rdy → ld_stall=0 the cycle after the pop.
- **Full with simultaneous drain:** with DEPTH=4, fill 4 entries, dc_wr_rdy=0 → enq_rdy=0, count=4. Set dc_wr_rdy=1 → count 3 next cycle, enq_rdy=1. Pointer wrap holds FIFO order across 10 back-to-back stores.
- **Uncached ordering and FWD_EN=0:** buffer non-empty, uncached load at a non-matching pa → ld_stall=1 until empty=1. With FWD_EN=0, an exact byte match → ld_stall=1, hit=0.
